// File: rtl/score_pkg.sv
// Shared types and default timing constants for the score keeper and its
// input filter.
package score_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_WIN
    } state_t;

    localparam int SCORE_W                 = 3;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_BLINK_CYCLES    = 25000000;

endpackage

// File: rtl/score_keeper_debounce.sv
// Two-flop synchronizer followed by a stable-count filter; dout only moves
// after the synchronized input has disagreed with it for DEBOUNCE_CYCLES cycles.
module debounce
    import score_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // Any agreement with the current level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign dout = r_level;

endmodule

// File: rtl/score_keeper.sv
// Game score producer: debounced hit events drive a saturating score through
// the IDLE/PLAY/WIN state machine, and WIN requests a blinking display.
module score_keeper
    import score_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int BLINK_CYCLES    = DEFAULT_BLINK_CYCLES,
    parameter int MAX_SCORE       = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hit_in,
    input  logic               start,
    input  logic               clear,
    output logic [SCORE_W-1:0] Score,
    output logic               win,
    output logic               blank,
    output logic               hit_ack
);

    localparam int                 BLINK_W    = $clog2(BLINK_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(MAX_SCORE);

    logic               w_level;
    logic               w_hitEvent;
    logic [SCORE_W-1:0] w_scoreNext;
    logic               r_levelD;
    state_t             r_state;
    logic [SCORE_W-1:0] r_score;
    logic               r_win;
    logic               r_blank;
    logic               r_hitAck;
    logic [BLINK_W-1:0] r_blinkCnt;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (hit_in),
        .dout (w_level)
    );

    // Only rising edges of the filtered level count; a held hit cannot re-fire.
    assign w_hitEvent  = w_level & ~r_levelD;
    assign w_scoreNext = r_score + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_levelD <= 1'b0;
        end else begin
            r_levelD <= w_level;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_score    <= '0;
            r_win      <= 1'b0;
            r_blank    <= 1'b0;
            r_hitAck   <= 1'b0;
            r_blinkCnt <= '0;
        end else begin
            r_hitAck <= 1'b0;
            if (clear) begin
                r_state    <= S_IDLE;
                r_score    <= '0;
                r_win      <= 1'b0;
                r_blank    <= 1'b0;
                r_blinkCnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_score <= '0;
                        if (start) begin
                            r_state <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (w_hitEvent) begin
                            r_hitAck <= 1'b1;
                            r_score  <= w_scoreNext;
                            if (w_scoreNext == SCORE_MAX) begin
                                r_state    <= S_WIN;
                                r_win      <= 1'b1;
                                r_blank    <= 1'b0;
                                r_blinkCnt <= '0;
                            end
                        end
                    end
                    S_WIN: begin
                        r_win   <= 1'b1;
                        r_score <= SCORE_MAX;
                        if (r_blinkCnt == BLINK_LAST) begin
                            r_blinkCnt <= '0;
                            r_blank    <= ~r_blank;
                        end else begin
                            r_blinkCnt <= r_blinkCnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign Score   = r_score;
    assign win     = r_win;
    assign blank   = r_blank;
    assign hit_ack = r_hitAck;

endmodule

// File: doc/score_keeper.md
# score_keeper

Game score producer that drives the 3-bit score bus consumed by the seven-segment score decoder. It turns a raw, bouncy hit input into clean single-count events, keeps a saturating score, and runs the IDLE/PLAY/WIN game state machine. In WIN it requests display blinking. It sits between the board inputs and the display path and is the only writer of the score bus.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed before the filtered hit level changes (10 ms at 50 MHz); legal values ≥ 2.
- BLINK_CYCLES, 25000000: half-period of the WIN blink, in clk cycles; legal values ≥ 2.
- MAX_SCORE, 7: winning score; legal range 1..7.
- clk  in  1  system clock; all logic runs in this single domain.
- rst_n  in  1  asynchronous, active-low reset.
- hit_in  in  1  raw hit input; asynchronous to clk and may bounce.
- start  in  1  synchronous single-cycle pulse that begins a game.
- clear  in  1  synchronous single-cycle pulse that aborts or ends a game.
- Score  out  3  current score, driven onto the decoder's Score input.
- win  out  1  high while in WIN.
- blank  out  1  display blank request; toggles in WIN only.
- hit_ack  out  1  one-cycle pulse for each accepted hit.

## Operation
- Reset (rst_n low) sets: state IDLE, Score 0, win 0, blank 0, hit_ack 0, synchronizer flops 0, filtered level 0, all counters 0.
- Synchronizer: hit_in passes through 2 flops to give hit_s.
- Debounce:
  - When hit_s differs from the filtered level, a counter increments each cycle. When hit_s equals the filtered level, the counter returns to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while hit_s still differs, the filtered level takes hit_s and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- A hit event is a rising edge of the filtered level, detected against a registered copy of that level. Falling edges are ignored.
- State IDLE: Score = 0; hit events are ignored and hit_ack stays 0; start moves to PLAY.
- State PLAY: each hit event raises hit_ack for 1 cycle and adds 1 to Score. If the new Score equals MAX_SCORE, the next state is WIN. Score never exceeds MAX_SCORE.
- State WIN: win = 1 and Score holds at MAX_SCORE. Hit events are ignored and hit_ack stays 0. The blink counter runs and blank toggles each BLINK_CYCLES cycles, starting from 0 on WIN entry.
- clear in any state: next state IDLE, Score 0, win 0, blank 0, blink counter 0.
- Simultaneous events:
  - clear with start: clear wins.
  - clear with a hit event: clear wins and hit_ack stays 0.
  - start in PLAY or WIN: ignored.
- The debounce path keeps running in every state. A hit held through IDLE→PLAY does not count unless a new rising edge of the filtered level occurs.
- Asserting rst_n low mid-game forces all outputs to their reset values immediately (asynchronous).

## Timing
- All outputs are registered.
- Hit latency: a hit_in rising edge that stays stable produces hit_ack, and Score+1 in the same cycle, exactly 2 + DEBOUNCE_CYCLES + 1 rising clk edges after the first edge sampling it high.
- start → state PLAY visible on the next edge.
- clear → Score 0, win 0 and blank 0 on the next edge.
- The final hit sets Score = MAX_SCORE and win = 1 on the same edge.
- blank's first toggle comes BLINK_CYCLES edges after win rises.
- A glitch shorter than DEBOUNCE_CYCLES cycles (after synchronization) never produces hit_ack.

## Structure
- Shared package score_pkg holds:
  - the state enum (S_IDLE, S_PLAY, S_WIN);
  - SCORE_W = 3;
  - the default DEBOUNCE_CYCLES and BLINK_CYCLES values.
- Sub-module debounce: the synchronizer plus the stable counter. Ports: clk, rst_n, din, dout. Parameter: DEBOUNCE_CYCLES. It is reused later for other buttons.
- score_keeper holds the edge detector, the FSM, the score register and the blink counter.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, MAX_SCORE=7.
- Reset: hold rst_n low with hit_in=1 → Score=0, win=0, blank=0, hit_ack=0 throughout. After release with no start, the state stays IDLE.
- Clean hit: pulse start, then hold hit_in high → hit_ack is high exactly 7 edges after hit_in is first sampled and Score goes from 0 to 1. Releasing and re-pressing gives Score=2.
- Bounce rejection: in PLAY, toggle hit_in every 2 cycles for 40 cycles, then settle at 0 → no hit_ack and Score unchanged. Then a 3-cycle pulse → no hit_ack.
- Win and blink: 7 clean hits → Score=7 and win=1 on the 7th hit_ack. blank toggles every 8 cycles. An 8th hit gives no hit_ack and Score stays 7.
- Clear priority: in PLAY at Score=3, assert clear in the same cycle a hit event fires → Score=0, state IDLE, hit_ack=0. clear with start in IDLE → still IDLE.
- Async reset mid-WIN: drop rst_n between clk edges while blank=1 → all outputs are 0 before the next edge. After release the block is in IDLE with Score=0.
